// File: rtl/vr_serialiser.sv
// vr_serialiser: splits IN_W-bit words into RATIO chunks of OUT_W bits,
// LSB chunk first, over valid/ready handshakes on both sides. A word can be
// accepted in the same cycle as the final chunk of the previous word leaves,
// so back-to-back words stream without bubble cycles.
module vr_serialiser #(
   parameter int IN_W  = 32,
   parameter int OUT_W = 8,
   parameter int RATIO = IN_W / OUT_W,
   parameter int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last
);

   typedef enum logic {
      IDLE = 1'b0,   // no word held
      SEND = 1'b1    // word held, chunks pending
   } state_e;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [IN_W-1:0]  hold_q,  hold_d;
   logic [IN_W-1:0]  shifted;
   logic             is_last;

   assign is_last = (cnt_q == LAST_CNT);

   // Bring the current chunk down to the bottom of the holding register.
   always_comb begin
      shifted = hold_q >> (OUT_W * int'(cnt_q));
   end

   // Next-state and output decode; everything is gated by rst and en.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the branches below can leave one unassigned and infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      hold_d    = hold_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_data  = '0;

      if (!rst) begin
         if (state_q == SEND) begin
            out_data = shifted[OUT_W-1:0];
         end
         if (en) begin
            unique case (state_q)
               IDLE: begin
                  in_ready = 1'b1;
                  if (in_valid) begin
                     hold_d  = in_data;
                     cnt_d   = '0;
                     state_d = SEND;
                  end
               end
               SEND: begin
                  out_valid = 1'b1;
                  out_last  = is_last;
                  // Only the final chunk frees the holding register, and only
                  // if it is leaving this very cycle.
                  in_ready  = out_ready & is_last;
                  if (out_ready) begin
                     if (is_last) begin
                        cnt_d = '0;
                        if (in_valid) begin
                           hold_d = in_data;
                        end else begin
                           state_d = IDLE;
                        end
                     end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                     end
                  end
               end
               default: begin
                  state_d = IDLE;
               end
            endcase
         end
      end
   end

   // State, chunk counter and holding register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed above, independent of statement order.
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         // NOTE: the holding register is cleared too, so nothing of a
         // discarded word can be observed after reset.
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
      end
   end

endmodule

// File: tb/tb_vr_serialiser.sv
// Bench for vr_serialiser: three instances (4, 1 and 3 chunks per word) share
// the stimulus. A queue of pending chunks per instance predicts every output
// on every cycle; directed scenarios pin the predictions with literal values.
module tb_vr_serialiser;

   logic        clk;
   logic        rst;
   logic        en;
   logic [31:0] in_data;
   logic        in_valid;
   logic        out_ready;

   logic       ir0, ov0, ol0;
   logic [7:0] od0;
   logic       ir1, ov1, ol1;
   logic [7:0] od1;
   logic       ir2, ov2, ol2;
   logic [7:0] od2;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   typedef struct {
      logic [7:0] d;
      logic       l;
      int         c;
   } rec_t;

   rec_t       seen[$];
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] q2[$];

   vr_serialiser #(.IN_W(32), .OUT_W(8)) u_dut (
      .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
      .in_ready(ir0), .out_data(od0), .out_valid(ov0), .out_ready(out_ready),
      .out_last(ol0)
   );

   vr_serialiser #(.IN_W(8), .OUT_W(8)) u_dut_r1 (
      .clk(clk), .rst(rst), .en(en), .in_data(in_data[7:0]), .in_valid(in_valid),
      .in_ready(ir1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready),
      .out_last(ol1)
   );

   vr_serialiser #(.IN_W(24), .OUT_W(8)) u_dut_r3 (
      .clk(clk), .rst(rst), .en(en), .in_data(in_data[23:0]), .in_valid(in_valid),
      .in_ready(ir2), .out_data(od2), .out_valid(ov2), .out_ready(out_ready),
      .out_last(ol2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // One cycle of the reference: the queue holds the chunks of the word in
   // flight that have not yet left, so its length alone fixes every output.
   task automatic model_cycle(input string tag, input int ratio,
                              input logic a_ir, input logic a_ov, input logic a_ol,
                              input logic [7:0] a_od,
                              input logic [7:0] q_in[$], output logic [7:0] q_out[$]);
      logic [7:0] q[$];
      logic       e_ir, e_ov, e_ol;
      logic [7:0] e_od;
      q    = q_in;
      e_ov = !rst && en && (q.size() != 0);
      e_ir = !rst && en && ((q.size() == 0) || ((q.size() == 1) && out_ready));
      e_ol = e_ov && (q.size() == 1);
      e_od = (rst || q.size() == 0) ? 8'h00 : q[0];
      check({tag, "_in_ready"},  32'(a_ir), 32'(e_ir));
      check({tag, "_out_valid"}, 32'(a_ov), 32'(e_ov));
      check({tag, "_out_last"},  32'(a_ol), 32'(e_ol));
      check({tag, "_out_data"},  32'(a_od), 32'(e_od));
      if (rst) begin
         q.delete();
      end else begin
         if (e_ov && out_ready) void'(q.pop_front());
         if (e_ir && in_valid)
            for (int i = 0; i < ratio; i++) q.push_back(8'(in_data >> (8 * i)));
      end
      q_out = q;
   endtask

   // Compare process: mid-cycle, inputs are stable until the next rising edge.
   initial begin
      rec_t r;
      forever begin
         @(negedge clk);
         cyc++;
         if (ov0 && out_ready) begin
            r.d = od0;
            r.l = ol0;
            r.c = cyc;
            seen.push_back(r);
         end
         model_cycle("r4", 4, ir0, ov0, ol0, od0, q0, q0);
         model_cycle("r1", 1, ir1, ov1, ol1, od1, q1, q1);
         model_cycle("r3", 3, ir2, ov2, ol2, od2, q2, q2);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   // Compare the recorded chunk stream of the 4-chunk instance with literals.
   task automatic expect_seen(input string tag, input logic [7:0] exp_d[$],
                              input int last_mask, input bit chk_span);
      check({tag, "_count"}, 32'(seen.size()), 32'(exp_d.size()));
      for (int i = 0; i < exp_d.size(); i++) begin
         check($sformatf("%s_data%0d", tag, i), 32'(seen[i].d), 32'(exp_d[i]));
         check($sformatf("%s_last%0d", tag, i), 32'(seen[i].l), 32'(last_mask >> i) & 32'd1);
      end
      if (chk_span && seen.size() == exp_d.size())
         check({tag, "_no_bubble"}, 32'(seen[seen.size()-1].c - seen[0].c),
               32'(exp_d.size() - 1));
   endtask

   initial begin
      logic [7:0] e[$];

      rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      repeat (3) step();
      settle();
      check("rst_in_ready", 32'(ir0), 32'd0);
      check("rst_out_valid", 32'(ov0), 32'd0);
      rst = 1'b0;
      step();

      // Single word, sink always ready.
      seen.delete();
      in_data = 32'hAABBCCDD; in_valid = 1'b1; out_ready = 1'b1;
      settle();
      check("t1_idle_in_ready", 32'(ir0), 32'd1);
      step();
      in_valid = 1'b0; in_data = '0;
      settle();
      check("t1_first_chunk", 32'(od0), 32'hDD);
      check("t1_first_valid", 32'(ov0), 32'd1);
      repeat (4) step();
      settle();
      check("t1_end_in_ready", 32'(ir0), 32'd1);
      check("t1_end_out_valid", 32'(ov0), 32'd0);
      e = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
      expect_seen("t1", e, 32'b1000, 1'b1);

      // Two words back to back.
      seen.delete();
      in_data = 32'h03020100; in_valid = 1'b1;
      step();
      in_data = 32'h07060504;
      repeat (3) step();
      settle();
      check("t2_handover_ready", 32'(ir0), 32'd1);
      check("t2_handover_data", 32'(od0), 32'h03);
      check("t2_handover_last", 32'(ol0), 32'd1);
      step();
      in_valid = 1'b0;
      repeat (4) step();
      e = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
      expect_seen("t2", e, 32'b1000_1000, 1'b1);

      // Sink stalls for 3 cycles on chunk CC.
      seen.delete();
      in_data = 32'hAABBCCDD; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         check("t3_stall_data", 32'(od0), 32'hCC);
         check("t3_stall_valid", 32'(ov0), 32'd1);
         check("t3_stall_last", 32'(ol0), 32'd0);
         check("t3_stall_in_ready", 32'(ir0), 32'd0);
         step();
      end
      out_ready = 1'b1;
      repeat (3) step();
      e = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
      expect_seen("t3", e, 32'b1000, 1'b0);

      // Reset mid-word discards the rest of it.
      seen.delete();
      in_data = 32'h11223344; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (2) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      settle();
      check("t4_post_rst_valid", 32'(ov0), 32'd0);
      check("t4_post_rst_ready", 32'(ir0), 32'd1);
      in_data = 32'h55667788; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (4) step();
      e = {8'h44, 8'h33, 8'h88, 8'h77, 8'h66, 8'h55};
      expect_seen("t4", e, 32'b10_0000, 1'b0);

      // Enable dropped for 2 cycles on chunk index 2.
      seen.delete();
      in_data = 32'hDEADBEEF; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (2) step();
      en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         settle();
         check("t5_en_low_valid", 32'(ov0), 32'd0);
         check("t5_en_low_ready", 32'(ir0), 32'd0);
         check("t5_en_low_last", 32'(ol0), 32'd0);
         step();
      end
      en = 1'b1;
      settle();
      check("t5_resume_data", 32'(od0), 32'hAD);
      check("t5_resume_valid", 32'(ov0), 32'd1);
      repeat (2) step();
      e = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
      expect_seen("t5", e, 32'b1000, 1'b0);

      // Random traffic; the compare process checks every cycle.
      seen.delete();
      for (int i = 0; i < 12000; i++) begin
         step();
         rst       = ($urandom_range(0, 599) == 0);
         en        = ($urandom_range(0, 9) != 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = (i % 2000 < 1000) ? ($urandom_range(0, 3) != 0)
                                       : ($urandom_range(0, 1) != 0);
         in_data   = $urandom;
      end
      step();
      rst = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      repeat (8) step();
      settle();
      check("drain_out_valid", 32'(ov0), 32'd0);
      check("drain_in_ready", 32'(ir0), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
